// File: rtl/rename_ctrl.sv
// Rename controller: circular free-list allocation, commit return, map recovery.
// Optional stall counter output enabled by RENAME_CTRL_STALL_CNT_EN.
module rename_ctrl #(
  parameter int PHYS_W = 6,
  parameter int ARCH_W = 5
) (
  input  logic              cpu_clk_i,
  input  logic              cpu_rstn_i,
  input  logic              rn_valid_i,
  input  logic              rn_ins0_we_i,
  input  logic              rn_ins1_we_i,
  input  logic [ARCH_W-1:0] rn_ins0_rd_i,
  input  logic [ARCH_W-1:0] rn_ins1_rd_i,
  output logic              rn_ready_o,
  output logic [PHYS_W-1:0] rn_p0_o,
  output logic [PHYS_W-1:0] rn_p1_o,
  output logic [ARCH_W-1:0] map_w0_logical_o,
  output logic [ARCH_W-1:0] map_w1_logical_o,
  output logic [PHYS_W-1:0] map_w0_phys_o,
  output logic [PHYS_W-1:0] map_w1_phys_o,
  output logic              map_w0_we_o,
  output logic              map_w1_we_o,
  input  logic              cm0_valid_i,
  input  logic              cm1_valid_i,
  input  logic [PHYS_W-1:0] cm0_old_i,
  input  logic [PHYS_W-1:0] cm1_old_i,
  input  logic              flush_i,
  output logic [ARCH_W-1:0] rrt_addr0_o,
  output logic [ARCH_W-1:0] rrt_addr1_o,
  input  logic [PHYS_W-1:0] rrt_data0_i,
  input  logic [PHYS_W-1:0] rrt_data1_i,
  output logic              recover_busy_o,
`ifdef RENAME_CTRL_STALL_CNT_EN
  output logic [31:0]       stall_cnt_o,
`endif
  output logic [PHYS_W-1:0] free_count_o
);

  localparam int FL_D = (1 << PHYS_W) - (1 << ARCH_W);
  localparam int IW   = $clog2(FL_D);
  localparam int PW   = IW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef enum logic {S_IDLE, S_RECOVER} state_t;

  logic [PHYS_W-1:0] r_fl [FL_D];
  ptr_t              r_spec_head;
  ptr_t              r_commit_head;
  ptr_t              r_tail;
  logic [PHYS_W-1:0] r_free_cnt;
  state_t            r_state;
  state_t            w_state_nxt;
  logic [ARCH_W-2:0] r_idx;
  logic [ARCH_W-2:0] w_idx_nxt;

  logic w_a0;
  logic w_a1;
  logic w_busy;
  logic w_acc;
  ptr_t w_need;
  ptr_t w_frees;
  ptr_t w_p1_ptr;
  ptr_t w_tail1;
  ptr_t w_tail_nxt;
  ptr_t w_ch_nxt;
  ptr_t w_sh_nxt;

  assign w_a0    = rn_ins0_we_i & (rn_ins0_rd_i != '0);
  assign w_a1    = rn_ins1_we_i & (rn_ins1_rd_i != '0);
  assign w_need  = ptr_t'(w_a0) + ptr_t'(w_a1);
  assign w_frees = ptr_t'(cm0_valid_i) + ptr_t'(cm1_valid_i);
  assign w_busy  = (r_state == S_RECOVER);

  assign rn_ready_o = !w_busy && !flush_i &&
                      (r_free_cnt >= PHYS_W'(w_need));
  assign w_acc      = rn_valid_i & rn_ready_o;

  // Instruction 1 takes the head entry when instruction 0 allocates nothing.
  assign w_p1_ptr = r_spec_head + ptr_t'(w_a0);
  assign rn_p0_o  = r_fl[r_spec_head[IW-1:0]];
  assign rn_p1_o  = r_fl[w_p1_ptr[IW-1:0]];

  assign w_tail1    = r_tail + ptr_t'(cm0_valid_i);
  assign w_tail_nxt = r_tail + w_frees;
  assign w_ch_nxt   = r_commit_head + w_frees;
  assign w_sh_nxt   = flush_i ? w_ch_nxt :
                      w_acc   ? r_spec_head + w_need :
                                r_spec_head;

  assign recover_busy_o = w_busy;
  assign free_count_o   = r_free_cnt;

  always_ff @(posedge cpu_clk_i or negedge cpu_rstn_i) begin
    if (!cpu_rstn_i) begin
      for (int i = 0; i < FL_D; i++) begin
        r_fl[i] <= PHYS_W'(FL_D + i);
      end
    end else begin
      if (cm0_valid_i) r_fl[r_tail[IW-1:0]]  <= cm0_old_i;
      if (cm1_valid_i) r_fl[w_tail1[IW-1:0]] <= cm1_old_i;
    end
  end

  always_ff @(posedge cpu_clk_i or negedge cpu_rstn_i) begin
    if (!cpu_rstn_i) begin
      r_spec_head   <= '0;
      r_commit_head <= '0;
      r_tail        <= ptr_t'(FL_D);
      r_free_cnt    <= PHYS_W'(FL_D);
      r_state       <= S_IDLE;
      r_idx         <= '0;
    end else begin
      r_spec_head   <= w_sh_nxt;
      r_commit_head <= w_ch_nxt;
      r_tail        <= w_tail_nxt;
      r_free_cnt    <= PHYS_W'(w_tail_nxt - w_sh_nxt);
      r_state       <= w_state_nxt;
      r_idx         <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_idx_nxt        = r_idx;
    rrt_addr0_o      = '0;
    rrt_addr1_o      = '0;
    map_w0_logical_o = rn_ins0_rd_i;
    map_w1_logical_o = rn_ins1_rd_i;
    map_w0_phys_o    = rn_p0_o;
    map_w1_phys_o    = rn_p1_o;
    map_w0_we_o      = w_acc & w_a0;
    map_w1_we_o      = w_acc & w_a1;
    unique case (r_state)
      S_IDLE: w_state_nxt = S_IDLE;
      S_RECOVER: begin
        rrt_addr0_o      = {r_idx, 1'b0};
        rrt_addr1_o      = {r_idx, 1'b1};
        map_w0_logical_o = {r_idx, 1'b0};
        map_w1_logical_o = {r_idx, 1'b1};
        map_w0_phys_o    = rrt_data0_i;
        map_w1_phys_o    = rrt_data1_i;
        map_w0_we_o      = 1'b1;
        map_w1_we_o      = 1'b1;
        w_idx_nxt        = r_idx + (ARCH_W-1)'(1);
        if (&r_idx) w_state_nxt = S_IDLE;
      end
    endcase
    // A new flush always restarts the copy from entry 0.
    if (flush_i) begin
      w_state_nxt = S_RECOVER;
      w_idx_nxt   = '0;
    end
  end

`ifdef RENAME_CTRL_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge cpu_clk_i or negedge cpu_rstn_i) begin
    if (!cpu_rstn_i) begin
      r_stall_cnt <= '0;
    end else if (rn_valid_i && !rn_ready_o) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`endif

endmodule
